lsu_align: RTL and testbench



---
 rtl/lsu_align.sv | 197 +++++++++++++++++++
 tb/tb_lsu_align.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load/store alignment unit turning b/h/w accesses into word accesses
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses report resp_err)
module lsu_align #(
  parameter logic [7:0] IO_PAGE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        mem_rd,
  output logic        mem_we
);

  typedef enum logic [1:0] {IDLE, RMW_WR, RESP} state_t;

  state_t      state;
  logic [31:0] rmw_addr;
  logic [31:0] rmw_data;

  logic [1:0]  size;
  logic        is_unsigned;
  logic        illegal;
  logic        misalign;
  logic        is_err;
  logic        is_io;
  logic        direct_store;
  logic [1:0]  lane;
  logic [4:0]  shamt;
  logic [31:0] aligned_addr;
  logic [31:0] low_mask;
  logic [31:0] lane_data;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign size         = req_funct3[1:0];
  assign is_unsigned  = req_funct3[2];
  assign aligned_addr = {req_addr[31:2], 2'b00};
  assign is_io        = (req_addr[15:8] == IO_PAGE);
  assign req_ready    = (state == IDLE);
  assign busy         = !req_ready;

  // Width code decode: reserved codes and unsigned-store codes are rejected
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b101:                 illegal = req_we;
      default:                illegal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((size == 2'b01) && req_addr[0]) ||
                    ((size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign is_err = illegal || misalign;

  // Lane select: low address bits not meaningful for the width are ignored
  always_comb begin
    lane     = 2'b00;
    low_mask = 32'hFFFF_FFFF;
    case (size)
      2'b00: begin
        lane     = req_addr[1:0];
        low_mask = 32'h0000_00FF;
      end
      2'b01: begin
        lane     = {req_addr[1], 1'b0};
        low_mask = 32'h0000_FFFF;
      end
      default: begin
        lane     = 2'b00;
        low_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign shamt     = {lane, 3'b000};
  assign lane_data = mem_dout >> shamt;
  assign merged    = (mem_dout & ~(low_mask << shamt)) | ((req_wdata & low_mask) << shamt);
  assign direct_store = (size == 2'b10) || is_io;

  // Load extension of the selected lane
  always_comb begin
    load_val = mem_dout;
    case (size)
      2'b00:   load_val = is_unsigned ? {24'h0, lane_data[7:0]}
                                      : {{24{lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_val = is_unsigned ? {16'h0, lane_data[15:0]}
                                      : {{16{lane_data[15]}}, lane_data[15:0]};
      default: load_val = mem_dout;
    endcase
  end

  // Memory port drive; reset kills enables immediately so no partial write lands
  always_comb begin
    mem_addr = 32'h0;
    mem_din  = 32'h0;
    mem_rd   = 1'b0;
    mem_we   = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr = aligned_addr;
            if (!is_err) begin
              if (!req_we) begin
                mem_rd = 1'b1;
              end else if (direct_store) begin
                mem_we  = 1'b1;
                mem_din = req_wdata & low_mask;
              end else begin
                mem_rd = 1'b1;
              end
            end
          end
        end
        RMW_WR: begin
          mem_addr = rmw_addr;
          mem_din  = rmw_data;
          mem_we   = 1'b1;
        end
        default: begin
          mem_addr = 32'h0;
        end
      endcase
    end
  end

  // Control FSM with registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      rmw_addr   <= 32'h0;
      rmw_data   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (is_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (!req_we) begin
              resp_err   <= 1'b0;
              resp_rdata <= load_val;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (direct_store) begin
              resp_err   <= 1'b0;
              resp_rdata <= 32'h0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              resp_err   <= 1'b0;
              resp_rdata <= 32'h0;
              rmw_addr   <= aligned_addr;
              rmw_data   <= merged;
              state      <= RMW_WR;
            end
          end
        end
        RMW_WR: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - directed self-checking bench for lsu_align
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_rd;
  logic        mem_we;

  logic [31:0] mem [0:15];
  logic [31:0] io_data = 32'h0;
  logic [31:0] io_addr = 32'h0;
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = 4'h0;
  logic [31:0] pre_data = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int we_cnt = 0;
  int lat;
  int rd0;
  int we0;

  lsu_align dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_rd     (mem_rd),
    .mem_we     (mem_we)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (mem_we) begin
      if (mem_addr[15:8] == 8'hFF) begin
        io_data <= mem_din;
        io_addr <= mem_addr;
      end else begin
        mem[mem_addr[5:2]] <= mem_din;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_rd) rd_cnt++;
    if (mem_we) we_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(posedge clk);
    #2;
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = val;
    @(posedge clk);
    #2;
    pre_we = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
    @(posedge clk);
    #2;
    rd0 = rd_cnt;
    we0 = we_cnt;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    #1;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_mem_en", {30'h0, mem_rd, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_busy", {31'h0, busy}, 32'h0);

    preload(4'd0, 32'h1122_3344);
    preload(4'd1, 32'hCAFE_F00D);
    preload(4'd2, 32'h0000_0000);
    preload(4'd3, 32'h0000_00F0);

    do_req(1'b0, 3'b000, 32'h003, 32'h0);
    check("lb3_lat", lat, 32'd1);
    check("lb3_data", resp_rdata, 32'h0000_0011);
    check("lb3_err", {31'h0, resp_err}, 32'h0);

    do_req(1'b0, 3'b100, 32'h001, 32'h0);
    check("lbu1_data", resp_rdata, 32'h0000_0033);

    do_req(1'b0, 3'b000, 32'h00C, 32'h0);
    check("lb_sign", resp_rdata, 32'hFFFF_FFF0);

    do_req(1'b0, 3'b100, 32'h00C, 32'h0);
    check("lbu_zero", resp_rdata, 32'h0000_00F0);

    preload(4'd0, 32'h8000_1234);
    do_req(1'b0, 3'b001, 32'h002, 32'h0);
    check("lh2_data", resp_rdata, 32'hFFFF_8000);
    do_req(1'b0, 3'b101, 32'h002, 32'h0);
    check("lhu2_data", resp_rdata, 32'h0000_8000);
    do_req(1'b0, 3'b001, 32'h000, 32'h0);
    check("lh0_data", resp_rdata, 32'h0000_1234);
    preload(4'd0, 32'h1122_3344);

    do_req(1'b1, 3'b000, 32'h001, 32'h0000_00AB);
    check("sb_lat", lat, 32'd2);
    check("sb_mem", mem[0], 32'h1122_AB44);
    check("sb_we_cnt", we_cnt - we0, 32'd1);
    check("sb_rd_cnt", rd_cnt - rd0, 32'd1);
    check("sb_rdata", resp_rdata, 32'h0);

    do_req(1'b1, 3'b001, 32'h002, 32'h1234_BEEF);
    check("sh_mem", mem[0], 32'hBEEF_AB44);

    do_req(1'b1, 3'b001, 32'hFF04, 32'h1234_BEEF);
    check("io_sh_lat", lat, 32'd1);
    check("io_sh_din", io_data, 32'h0000_BEEF);
    check("io_sh_addr", io_addr, 32'h0000_FF04);
    check("io_sh_rd_cnt", rd_cnt - rd0, 32'd0);
    check("io_sh_we_cnt", we_cnt - we0, 32'd1);

    do_req(1'b1, 3'b010, 32'h008, 32'hDEAD_BEEF);
    check("sw_lat", lat, 32'd1);
    check("sw_mem", mem[2], 32'hDEAD_BEEF);
    check("sw_rd_cnt", rd_cnt - rd0, 32'd0);

    do_req(1'b0, 3'b010, 32'h006, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw6_err", {31'h0, resp_err}, 32'h1);
    check("lw6_data", resp_rdata, 32'h0);
    check("lw6_rd_cnt", rd_cnt - rd0, 32'd0);
`else
    check("lw6_err", {31'h0, resp_err}, 32'h0);
    check("lw6_data", resp_rdata, 32'hCAFE_F00D);
    check("lw6_rd_cnt", rd_cnt - rd0, 32'd1);
`endif

    do_req(1'b0, 3'b011, 32'h000, 32'h0);
    check("ill011_err", {31'h0, resp_err}, 32'h1);
    check("ill011_data", resp_rdata, 32'h0);
    check("ill011_mem", rd_cnt - rd0 + we_cnt - we0, 32'd0);

    do_req(1'b1, 3'b101, 32'h000, 32'h0000_5555);
    check("ill_shu_err", {31'h0, resp_err}, 32'h1);
    check("ill_shu_mem", mem[0], 32'hBEEF_AB44);

    // Reset during the write phase of a read-modify-write
    @(posedge clk);
    #2;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h008;
    req_wdata  = 32'h0000_0055;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    check("rmw_busy", {31'h0, busy}, 32'h1);
    check("rmw_we_before", {31'h0, mem_we}, 32'h1);
    rst = 1'b1;
    #1;
    check("rmw_we_rst", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rmw_mem_kept", mem[2], 32'hDEAD_BEEF);
    check("rmw_ready", {31'h0, req_ready}, 32'h1);
    check("rmw_no_resp", {31'h0, resp_valid}, 32'h0);

    // Back-to-back with req_valid held high
    @(posedge clk);
    #2;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h00C;
    req_wdata  = 32'h1234_5678;
    @(posedge clk);
    #2;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    @(negedge clk);
    check("b2b_resp1", {31'h0, resp_valid}, 32'h1);
    check("b2b_busy", {31'h0, busy}, 32'h1);
    check("b2b_no_rd_in_resp", {31'h0, mem_rd}, 32'h0);
    @(negedge clk);
    check("b2b_ready2", {31'h0, req_ready}, 32'h1);
    check("b2b_rd2", {31'h0, mem_rd}, 32'h1);
    check("b2b_addr2", mem_addr, 32'h0000_000C);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_resp2", {31'h0, resp_valid}, 32'h1);
    check("b2b_data2", resp_rdata, 32'h1234_5678);
    @(negedge clk);
    check("b2b_pulse", {31'h0, resp_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
